// File: rtl/ascon_collector_pkg.sv
// ascon_collector_pkg: shared state encoding and FIFO entry packing for the ciphertext collector
package ascon_collector_pkg;
  typedef enum logic {IDLE, WAIT_LOW} state_e;
  localparam int unsigned CT_DEPTH   = 4;
  localparam int unsigned CT_DATA_W  = 128;
  localparam int unsigned CT_BYTES_W = 5;
  localparam int unsigned CT_TAG_W   = 128;
  // Entry layout is {last, bytes, data}: bytes start at data width, last sits above bytes
  function automatic int unsigned entry_w(input int unsigned dw, input int unsigned bw);
    return dw + bw + 1;
  endfunction
endpackage

// File: rtl/ascon_ct_fifo.sv
// ascon_ct_fifo: synchronous first-word-fall-through FIFO with flush and occupancy count
module ascon_ct_fifo #(
  parameter int pWIDTH = 134,
  parameter int pDEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     clear_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [pWIDTH-1:0]        din_i,
  output logic [pWIDTH-1:0]        dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(pDEPTH):0]  count_o
);
  localparam int AW = $clog2(pDEPTH);
  logic [pWIDTH-1:0] mem_q [pDEPTH];
  logic [AW-1:0]     wr_q, rd_q;
  logic [AW:0]       cnt_q;
  logic              wr_en, rd_en;
  assign empty_o = cnt_q == '0;
  assign full_o  = cnt_q == (AW+1)'(pDEPTH);
  // A pop frees the slot in the same cycle, so a full FIFO may still accept a push
  assign wr_en   = push_i & (~full_o | pop_i);
  assign rd_en   = pop_i & ~empty_o;
  assign dout_o  = mem_q[rd_q];
  assign count_o = cnt_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < pDEPTH; i++) mem_q[i] <= '0;
    end else if (clear_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (wr_en) mem_q[wr_q] <= din_i;
      wr_q  <= wr_q + AW'(wr_en);
      rd_q  <= rd_q + AW'(rd_en);
      cnt_q <= cnt_q + (AW+1)'(wr_en) - (AW+1)'(rd_en);
    end
  end
endmodule

// File: rtl/ascon_ct_collector.sv
// ascon_ct_collector: captures core ciphertext blocks into a FWFT FIFO, acknowledges the core,
// latches the tag and keeps sticky done/overflow/underflow status.
module ascon_ct_collector
  import ascon_collector_pkg::*;
#(
  parameter int pDEPTH       = CT_DEPTH,
  parameter int pDATA_WIDTH  = CT_DATA_W,
  parameter int pTAG_WIDTH   = CT_TAG_W,
  parameter int pBYTES_WIDTH = CT_BYTES_W
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      ct_valid_i,
  input  logic [pDATA_WIDTH-1:0]    ct_data_i,
  input  logic [pBYTES_WIDTH-1:0]   ct_bytes_i,
  input  logic                      ct_last_i,
  input  logic                      tag_ready_i,
  input  logic [pTAG_WIDTH/2-1:0]   tag1_i,
  input  logic [pTAG_WIDTH/2-1:0]   tag2_i,
  output logic                      read_data_o,
  input  logic                      clear_i,
  input  logic                      pop_i,
  output logic                      rd_valid_o,
  output logic [pDATA_WIDTH-1:0]    rd_data_o,
  output logic [pBYTES_WIDTH-1:0]   rd_bytes_o,
  output logic                      rd_last_o,
  output logic [$clog2(pDEPTH):0]   fifo_count_o,
  output logic [pTAG_WIDTH-1:0]     tag_o,
  output logic                      tag_valid_o,
  output logic                      done_o,
  output logic                      tag_ovf_o,
  output logic                      underflow_o
);
  localparam int EW = int'(entry_w(pDATA_WIDTH, pBYTES_WIDTH));
  state_e                  state_q;
  logic                    read_data_q, tag_rdy_q, tag_valid_q, tag_ovf_q, underflow_q;
  logic [pTAG_WIDTH-1:0]   tag_q;
  logic [EW-1:0]           head;
  logic                    full, empty, capture, tag_rise;
  assign capture  = (state_q == IDLE) & ct_valid_i & (~full | pop_i) & ~clear_i;
  assign tag_rise = tag_ready_i & ~tag_rdy_q;
  ascon_ct_fifo #(.pWIDTH(EW), .pDEPTH(pDEPTH)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .clear_i (clear_i),
    .push_i  (capture),
    .pop_i   (pop_i & ~clear_i),
    .din_i   ({ct_last_i, ct_bytes_i, ct_data_i}),
    .dout_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (fifo_count_o)
  );
  assign {rd_last_o, rd_bytes_o, rd_data_o} = head;
  assign rd_valid_o  = ~empty;
  assign read_data_o = read_data_q;
  assign tag_o       = tag_q;
  assign tag_valid_o = tag_valid_q;
  assign tag_ovf_o   = tag_ovf_q;
  assign underflow_o = underflow_q;
  assign done_o      = tag_valid_q & empty & (state_q == IDLE);
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      read_data_q <= 1'b0;
      tag_rdy_q   <= 1'b0;
      tag_valid_q <= 1'b0;
      tag_ovf_q   <= 1'b0;
      underflow_q <= 1'b0;
      tag_q       <= '0;
    end else begin
      read_data_q <= capture;
      tag_rdy_q   <= tag_ready_i;
      if (clear_i) begin
        state_q     <= ct_valid_i ? WAIT_LOW : IDLE;
        tag_valid_q <= 1'b0;
        tag_ovf_q   <= 1'b0;
        underflow_q <= 1'b0;
        tag_q       <= '0;
      end else begin
        // WAIT_LOW holds until the core drops valid, so each handshake is captured once
        state_q     <= capture ? WAIT_LOW : (state_q == WAIT_LOW && !ct_valid_i) ? IDLE : state_q;
        underflow_q <= underflow_q | (pop_i & empty);
        if (tag_rise) begin
          tag_q       <= {tag2_i, tag1_i};
          tag_valid_q <= 1'b1;
          tag_ovf_q   <= tag_ovf_q | tag_valid_q;
        end
      end
    end
  end
endmodule

// File: tb/tb_ascon_ct_collector.sv
// tb_ascon_ct_collector: scoreboard bench; stimulus queues expected blocks, monitor checks them on pop
module tb_ascon_ct_collector;
  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         ct_valid_i = 1'b0;
  logic [127:0] ct_data_i = '0;
  logic [4:0]   ct_bytes_i = '0;
  logic         ct_last_i = 1'b0;
  logic         tag_ready_i = 1'b0;
  logic [63:0]  tag1_i = '0, tag2_i = '0;
  logic         clear_i = 1'b0, pop_i = 1'b0;
  logic         read_data_o, rd_valid_o, rd_last_o, tag_valid_o, done_o, tag_ovf_o, underflow_o;
  logic [127:0] rd_data_o, tag_o;
  logic [4:0]   rd_bytes_o;
  logic [2:0]   fifo_count_o;
  int           checks = 0, errors = 0, acks = 0;
  logic [133:0] exp_q [$];

  ascon_ct_collector dut (
    .clk(clk), .reset_n(reset_n), .ct_valid_i(ct_valid_i), .ct_data_i(ct_data_i),
    .ct_bytes_i(ct_bytes_i), .ct_last_i(ct_last_i), .tag_ready_i(tag_ready_i),
    .tag1_i(tag1_i), .tag2_i(tag2_i), .read_data_o(read_data_o), .clear_i(clear_i),
    .pop_i(pop_i), .rd_valid_o(rd_valid_o), .rd_data_o(rd_data_o), .rd_bytes_o(rd_bytes_o),
    .rd_last_o(rd_last_o), .fifo_count_o(fifo_count_o), .tag_o(tag_o),
    .tag_valid_o(tag_valid_o), .done_o(done_o), .tag_ovf_o(tag_ovf_o), .underflow_o(underflow_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (reset_n && read_data_o) acks++;
    if (reset_n && pop_i && rd_valid_o) begin
      if (exp_q.size() == 0) chk("pop_unexpected", 128'd1, 128'd0);
      else begin
        logic [133:0] e;
        e = exp_q.pop_front();
        chk("pop_data", rd_data_o, e[127:0]);
        chk("pop_bytes", 128'(rd_bytes_o), 128'(e[132:128]));
        chk("pop_last", 128'(rd_last_o), 128'(e[133]));
      end
    end
  end

  task automatic push_blk(input logic [127:0] d, input logic [4:0] b, input logic l);
    bit got = 0;
    exp_q.push_back({l, b, d});
    ct_data_i = d; ct_bytes_i = b; ct_last_i = l; ct_valid_i = 1'b1;
    for (int i = 0; i < 8 && !got; i++) begin
      tick();
      got = read_data_o;
    end
    if (!got) chk("ack_timeout", 128'd0, 128'd1);
    ct_valid_i = 1'b0;
    tick();
  endtask

  task automatic pop1();
    pop_i = 1'b1;
    tick();
    pop_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    tick();
    tick();
    chk("rst_read_data", 128'(read_data_o), 128'd0);
    chk("rst_rd_valid", 128'(rd_valid_o), 128'd0);
    chk("rst_count", 128'(fifo_count_o), 128'd0);
    chk("rst_rd_data", rd_data_o, 128'd0);
    chk("rst_tag", tag_o, 128'd0);
    chk("rst_flags", 128'({tag_valid_o, done_o, tag_ovf_o, underflow_o}), 128'd0);
    reset_n = 1'b1;
    tick();

    // single block, valid held longer than the handshake
    ct_data_i = 128'h00112233_44556677_8899AABB_CCDDEEFF; ct_bytes_i = 5'd16; ct_last_i = 1'b1;
    ct_valid_i = 1'b1;
    exp_q.push_back({1'b1, 5'd16, 128'h00112233_44556677_8899AABB_CCDDEEFF});
    tick();
    chk("t1_ack", 128'(read_data_o), 128'd1);
    chk("t1_rd_valid", 128'(rd_valid_o), 128'd1);
    chk("t1_rd_data", rd_data_o, 128'h00112233_44556677_8899AABB_CCDDEEFF);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t1_no_second_ack", 128'(read_data_o), 128'd0);
      chk("t1_count", 128'(fifo_count_o), 128'd1);
    end
    ct_valid_i = 1'b0;
    tick();
    pop1();
    chk("t1_empty", 128'(fifo_count_o), 128'd0);

    // fill to depth, stall the fifth, release it with a pop
    for (int i = 1; i <= 4; i++) push_blk(128'(i) * 128'h1111, 5'(i), 1'b0);
    chk("t2_full", 128'(fifo_count_o), 128'd4);
    ct_data_i = 128'h5555; ct_bytes_i = 5'd5; ct_last_i = 1'b1; ct_valid_i = 1'b1;
    exp_q.push_back({1'b1, 5'd5, 128'h5555});
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t2_stall_ack", 128'(read_data_o), 128'd0);
      chk("t2_stall_count", 128'(fifo_count_o), 128'd4);
    end
    pop_i = 1'b1;
    tick();
    pop_i = 1'b0;
    chk("t2_pop_push_ack", 128'(read_data_o), 128'd1);
    chk("t2_pop_push_count", 128'(fifo_count_o), 128'd4);
    ct_valid_i = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) pop1();
    chk("t2_drained", 128'(fifo_count_o), 128'd0);

    // ordering across pointer wrap
    push_blk(128'hAAAA, 5'd16, 1'b0);
    push_blk(128'hBBBB, 5'd12, 1'b0);
    push_blk(128'hCCCC, 5'd3, 1'b0);
    pop1();
    pop1();
    chk("t3_count1", 128'(fifo_count_o), 128'd1);
    push_blk(128'hDDDD, 5'd1, 1'b0);
    push_blk(128'hEEEE, 5'd16, 1'b0);
    push_blk(128'hFFFF, 5'd7, 1'b1);
    chk("t3_count4", 128'(fifo_count_o), 128'd4);
    for (int i = 0; i < 4; i++) pop1();

    // tag capture, done, overflow
    push_blk(128'h7777, 5'd16, 1'b0);
    tag2_i = 64'hDEADBEEF_00000001; tag1_i = 64'hCAFEBABE_00000002; tag_ready_i = 1'b1;
    tick();
    chk("t4_tag", tag_o, 128'hDEADBEEF00000001_CAFEBABE00000002);
    chk("t4_tag_valid", 128'(tag_valid_o), 128'd1);
    chk("t4_done_nonempty", 128'(done_o), 128'd0);
    pop1();
    chk("t4_done", 128'(done_o), 128'd1);
    chk("t4_no_ovf", 128'(tag_ovf_o), 128'd0);
    tag_ready_i = 1'b0;
    tick();
    tag2_i = 64'h0123456789ABCDEF;
    tag_ready_i = 1'b1;
    tick();
    tag_ready_i = 1'b0;
    chk("t4_ovf", 128'(tag_ovf_o), 128'd1);
    chk("t4_tag2", tag_o, 128'h0123456789ABCDEF_CAFEBABE00000002);

    // pop while empty, then clear against push and pop
    pop1();
    chk("t5_underflow", 128'(underflow_o), 128'd1);
    chk("t5_underflow_count", 128'(fifo_count_o), 128'd0);
    push_blk(128'h9999, 5'd9, 1'b0);
    ct_data_i = 128'hBAD; ct_valid_i = 1'b1; pop_i = 1'b1; clear_i = 1'b1;
    tick();
    pop_i = 1'b0; clear_i = 1'b0;
    chk("t5_clr_count", 128'(fifo_count_o), 128'd0);
    chk("t5_clr_ack", 128'(read_data_o), 128'd0);
    chk("t5_clr_flags", 128'({tag_valid_o, tag_ovf_o, underflow_o, done_o}), 128'd0);
    chk("t5_clr_tag", tag_o, 128'd0);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("t5_wait_low_ack", 128'(read_data_o), 128'd0);
      chk("t5_wait_low_count", 128'(fifo_count_o), 128'd0);
    end
    ct_valid_i = 1'b0;
    tick();

    // reset while an acknowledge is being presented
    ct_data_i = 128'h1234; ct_bytes_i = 5'd2; ct_last_i = 1'b0; ct_valid_i = 1'b1;
    tick();
    chk("t6_ack_due", 128'(read_data_o), 128'd1);
    reset_n = 1'b0;
    #1;
    chk("t6_rst_ack", 128'(read_data_o), 128'd0);
    chk("t6_rst_rd_valid", 128'(rd_valid_o), 128'd0);
    chk("t6_rst_count", 128'(fifo_count_o), 128'd0);
    chk("t6_rst_rd_data", rd_data_o, 128'd0);
    ct_valid_i = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    push_blk(128'h600D, 5'd16, 1'b1);
    chk("t6_resume_count", 128'(fifo_count_o), 128'd1);
    pop1();

    chk("scoreboard_empty", 128'(exp_q.size()), 128'd0);
    chk("ack_total", 128'(acks), 128'd15);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
